// File: rtl/decode_stage_if.sv
// Bundle between the IF/ID register, register file and the ID/EX consumers.
interface decode_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            flush;
  logic            id_stall;
  logic [RW-1:0]   rs1_addr;
  logic [RW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [RW-1:0]   ex_rs1_addr;
  logic [RW-1:0]   ex_rs2_addr;
  logic [RW-1:0]   ex_rd_addr;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_op;
  logic [7:0]      ex_ctrl;

  // Decode stage side
  modport master (
    input  if_valid, if_pc, if_instr, flush, rs1_data, rs2_data,
    output id_stall, rs1_addr, rs2_addr,
           ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct3, ex_alu_op, ex_ctrl
  );

  // Surrounding pipeline side
  modport slave (
    output if_valid, if_pc, if_instr, flush, rs1_data, rs2_data,
    input  id_stall, rs1_addr, rs2_addr,
           ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct3, ex_alu_op, ex_ctrl
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I instruction decode stage: control/immediate decode, ID/EX register,
// load-use hazard stall and branch flush.
// Optional feature macro: LOAD_USE_STALL_EN (hardware load-use interlock).
module decode_stage #(
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input logic            clk,
  input logic            rst,
  decode_stage_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam int unsigned C_ILLEGAL = 7;
  localparam int unsigned C_JUMP    = 6;
  localparam int unsigned C_BRANCH  = 5;
  localparam int unsigned C_REG_WR  = 4;
  localparam int unsigned C_MEM_WR  = 3;
  localparam int unsigned C_MEM_RD  = 2;
  localparam int unsigned C_SRC_PC  = 1;
  localparam int unsigned C_SRC_IMM = 0;

  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7b5;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu;
  logic [7:0]      dec_ctrl;
  logic [RW-1:0]   dec_rd;
  logic [3:0]      f3_alu;

  logic            hazard;
  logic            load_bubble;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [RW-1:0]   ex_rs1_addr_q, ex_rs2_addr_q, ex_rd_addr_q;
  logic [2:0]      ex_funct3_q;
  logic [3:0]      ex_alu_op_q;
  logic [7:0]      ex_ctrl_q;

  assign instr  = bus.if_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];

  // Sign-extended immediates for every format
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign bus.rs1_addr = instr[19:15];
  assign bus.rs2_addr = instr[24:20];

  // ALU operation selected by funct3 for OP / OP-IMM
  always_comb begin
    f3_alu = ALU_ADD;
    case (funct3)
      3'd0: f3_alu = (opcode == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1: f3_alu = ALU_SLL;
      3'd2: f3_alu = ALU_SLT;
      3'd3: f3_alu = ALU_SLTU;
      3'd4: f3_alu = ALU_XOR;
      3'd5: f3_alu = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6: f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  end

  // Main control and immediate decode
  always_comb begin
    dec_imm  = '0;
    dec_alu  = ALU_ADD;
    dec_ctrl = '0;
    dec_rd   = instr[11:7];
    case (opcode)
      OPC_LUI: begin
        dec_imm  = imm_u;
        dec_alu  = ALU_PASS_B;
        dec_ctrl[C_REG_WR]  = 1'b1;
        dec_ctrl[C_SRC_IMM] = 1'b1;
      end
      OPC_AUIPC: begin
        dec_imm  = imm_u;
        dec_ctrl[C_REG_WR]  = 1'b1;
        dec_ctrl[C_SRC_PC]  = 1'b1;
        dec_ctrl[C_SRC_IMM] = 1'b1;
      end
      OPC_JAL: begin
        dec_imm  = imm_j;
        dec_ctrl[C_JUMP]   = 1'b1;
        dec_ctrl[C_REG_WR] = 1'b1;
      end
      OPC_JALR: begin
        dec_imm  = imm_i;
        dec_ctrl[C_JUMP]   = 1'b1;
        dec_ctrl[C_REG_WR] = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm  = imm_b;
        dec_alu  = ALU_SUB;
        dec_rd   = '0;
        dec_ctrl[C_BRANCH] = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm  = imm_i;
        dec_ctrl[C_MEM_RD]  = 1'b1;
        dec_ctrl[C_REG_WR]  = 1'b1;
        dec_ctrl[C_SRC_IMM] = 1'b1;
      end
      OPC_STORE: begin
        dec_imm  = imm_s;
        dec_rd   = '0;
        dec_ctrl[C_MEM_WR]  = 1'b1;
        dec_ctrl[C_SRC_IMM] = 1'b1;
      end
      OPC_OPIMM: begin
        dec_imm  = imm_i;
        dec_alu  = f3_alu;
        dec_ctrl[C_REG_WR]  = 1'b1;
        dec_ctrl[C_SRC_IMM] = 1'b1;
      end
      OPC_OP: begin
        dec_alu  = f3_alu;
        dec_ctrl[C_REG_WR] = 1'b1;
      end
      default: begin
        dec_rd   = '0;
        dec_ctrl[C_ILLEGAL] = 1'b1;
      end
    endcase
    if (dec_rd == '0) dec_ctrl[C_REG_WR] = 1'b0;
  end

`ifdef LOAD_USE_STALL_EN
  logic use_rs1;
  logic use_rs2;

  // Which source registers the instruction in ID actually reads
  always_comb begin
    use_rs1 = opcode inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    use_rs2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  end

  assign hazard = bus.if_valid && ex_valid_q && ex_ctrl_q[C_MEM_RD] && (ex_rd_addr_q != '0) &&
                  ((use_rs1 && (instr[19:15] == ex_rd_addr_q)) ||
                   (use_rs2 && (instr[24:20] == ex_rd_addr_q)));
`else
  assign hazard = 1'b0;
`endif

  // A flush kills the ID instruction outright, so IF must not hold it
  assign bus.id_stall = hazard && !bus.flush;
  assign load_bubble  = !bus.if_valid || bus.flush || hazard;

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_funct3_q   <= '0;
      ex_alu_op_q   <= '0;
    end else if (load_bubble) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      if (ZERO_BUBBLE) begin
        ex_pc_q       <= '0;
        ex_rs1_data_q <= '0;
        ex_rs2_data_q <= '0;
        ex_imm_q      <= '0;
        ex_rs1_addr_q <= '0;
        ex_rs2_addr_q <= '0;
        ex_rd_addr_q  <= '0;
        ex_funct3_q   <= '0;
        ex_alu_op_q   <= '0;
      end
    end else begin
      ex_valid_q    <= 1'b1;
      ex_ctrl_q     <= dec_ctrl;
      ex_pc_q       <= bus.if_pc;
      ex_rs1_data_q <= bus.rs1_data;
      ex_rs2_data_q <= bus.rs2_data;
      ex_imm_q      <= dec_imm;
      ex_rs1_addr_q <= instr[19:15];
      ex_rs2_addr_q <= instr[24:20];
      ex_rd_addr_q  <= dec_rd;
      ex_funct3_q   <= funct3;
      ex_alu_op_q   <= dec_alu;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_rs1_data = ex_rs1_data_q;
  assign bus.ex_rs2_data = ex_rs2_data_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rs1_addr = ex_rs1_addr_q;
  assign bus.ex_rs2_addr = ex_rs2_addr_q;
  assign bus.ex_rd_addr  = ex_rd_addr_q;
  assign bus.ex_funct3   = ex_funct3_q;
  assign bus.ex_alu_op   = ex_alu_op_q;
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the 5-stage RV32I pipeline: takes the IF/ID instruction, drives the register-file read addresses, decodes control and immediate, and captures everything into the ID/EX pipeline register. Also detects load-use hazards, where it stalls IF and inserts a bubble, and applies the branch flush from EX.
## Interface
- ZERO_BUBBLE, default 1, meaning: 1 = bubbles zero every ex_* data field; 0 = data fields hold their previous value and only ex_valid/ex_ctrl are cleared.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_pc  in  32  PC of the IF/ID instruction
- if_instr  in  32  IF/ID instruction word
- flush  in  1  EX resolved a taken branch/jump; kill the instruction in ID
- id_stall  out  1  combinational; IF holds PC and IF/ID this cycle
- rs1_addr  out  5  combinational, if_instr[19:15], to register file
- rs2_addr  out  5  combinational, if_instr[24:20], to register file
- rs1_data  in  32  register-file read data (includes same-cycle WB forwarding)
- rs2_data  in  32  register-file read data
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  32 each  registered PC, operands and sign-extended immediate
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each  registered register indices (for EX forwarding)
- ex_funct3  out  3  registered instr[14:12]
- ex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- ex_ctrl  out  8  {illegal, jump, branch, reg_write, mem_write, mem_read, alu_src_pc, alu_src_imm}
## Operation
- Opcodes: LUI 0110111 (PASS_B, imm U); AUIPC 0010111 (ADD, src_pc, src_imm); JAL 1101111 / JALR 1100111 (jump, reg_write, ADD; imm J / I); BRANCH 1100011 (branch, SUB, imm B); LOAD 0000011 (mem_read, reg_write, ADD, imm I); STORE 0100011 (mem_write, ADD, imm S); OP-IMM 0010011 / OP 0110011 (alu_op from funct3, plus funct7[5] for SUB/SRA; OP-IMM uses funct7[5] only for SRAI).
- Any other opcode: ex_valid=1 and ex_ctrl=8'h80 (illegal only); no write or memory enable is set.
- Immediates are sign-extended from instr[31]. U-type is {instr[31:12],12'b0}. B-type and J-type have bit 0 = 0.
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP. rs2 is used by BRANCH, STORE and OP.
- ex_rd_addr = 0 for BRANCH, STORE and illegal instructions. reg_write is forced to 0 when rd = 0.
- Load-use hazard condition: if_valid && ex_valid && ex_ctrl[mem_read] && ex_rd_addr != 0 && a used rs matches ex_rd_addr. On a hazard: id_stall=1 and a bubble is loaded into ID/EX.
- Bubble: ex_valid=0 and ex_ctrl=0. Data fields follow ZERO_BUBBLE.
- Priority order: rst > flush > hazard > normal load. If flush and hazard occur together, a bubble is loaded and id_stall=0.
- When if_valid=0, a bubble is loaded and id_stall=0.
## Timing
- Latency: if_* to ex_* is 1 clock. rs1_addr/rs2_addr and id_stall are combinational from the current inputs and ID/EX state.
- A load-use stall lasts exactly one cycle. The bubble clears mem_read, so the stalled instruction issues on the next edge with the loaded value forwarded by EX/MEM.
- rs1_data/rs2_data are sampled at the same edge that a WB write to the same register completes. The register file supplies the forwarded value, so no extra stall is needed.
- Reset (asynchronous, at any point including mid-stall): all ex_* outputs go to 0 immediately and id_stall=0. The first load occurs at the first rising edge after rst falls.
## Configuration
- LOAD_USE_STALL_EN defined: hazard detection and stall operate as described above.
- LOAD_USE_STALL_EN undefined: id_stall is tied to 0 and no hazard bubble is inserted. Software must NOP-pad load-use pairs. Flush behaviour is unchanged.
## Test plan
- Reset with ex_* non-zero, asserting rst between edges -> all ex_* = 0 without waiting for a clock edge; id_stall=0.
- addi x5,x0,-3 (0xFFD00293), if_pc=0x100 -> one cycle later: ex_imm=0xFFFFFFFD, ex_rd_addr=5, ex_alu_op=0, ex_ctrl=8'h11, ex_pc=0x100.
- lw x6,0(x1) followed by add x7,x6,x2 -> id_stall=1 for exactly one cycle, ex_valid=0 for one cycle, then the add issues with ex_rs1_addr=6.
- lw x6 followed by add x7,x6,x2 with flush=1 in the hazard cycle -> id_stall=0 and ex_valid=0 next cycle.
- beq x1,x2,-8 (0xFE208CE3) -> ex_imm=0xFFFFFFF8, ex_rd_addr=0, ex_ctrl=8'h20, ex_alu_op=1.
- Opcode 0x7F -> ex_valid=1, ex_ctrl=8'h80. sw x6 with LOAD_USE_STALL_EN undefined after a load to x6 -> id_stall stays 0.
